// File: rtl/lsu_subword_rmw_if.sv
// lsu_subword_rmw_if: MEM-stage request and data-memory bus of the load/store unit.
interface lsu_subword_rmw_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        access_fault;
    logic [31:0] store_count;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  load_data, stall, access_fault, store_count, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output load_data, stall, access_fault, store_count, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: load extension, sb/sh read-modify-write, fault checks and store counter.
module lsu_subword_rmw #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_WORDS = 2000
) (
    input logic              clk,
    input logic              rst_n,
    lsu_subword_rmw_if.slave bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    state_t      state;
    logic [31:0] merge_q;
    logic [31:0] count_q;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        misaligned, illegal, out_of_range, fault, ok;
    logic        is_load, is_sw, is_sub, idle;

    assign f3   = bus.req_funct3;
    assign a    = bus.req_addr;
    assign idle = state == IDLE;

    assign misaligned   = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
    assign illegal      = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
                          ((f3 == 3'b100 || f3 == 3'b101) && bus.req_we);
    assign out_of_range = a < BASE_ADDR || {1'b0, a} >= LIMIT;
    assign fault        = misaligned | illegal | out_of_range;
    assign ok           = idle & bus.req_valid & ~fault;

    assign is_load = ok & ~bus.req_we;
    assign is_sw   = ok & bus.req_we & f3 == 3'b010;
    assign is_sub  = ok & bus.req_we & (f3 == 3'b000 || f3 == 3'b001);

    assign bus.access_fault = idle & bus.req_valid & fault;
    // rst_n gating keeps a pending request from clobbering memory during reset
    assign bus.mem_we       = rst_n & (is_sw | state == WRITE);
    assign bus.stall        = rst_n & is_sub;
    assign bus.mem_addr     = {a[31:2], 2'b00};
    assign bus.mem_wdata    = state == WRITE ? merge_q : bus.req_wdata;
    assign bus.store_count  = count_q;

    assign byte_sel = bus.mem_rdata[8*a[1:0] +: 8];
    assign half_sel = a[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    assign bus.load_data = !is_load      ? 32'h0 :
                           f3 == 3'b000  ? {{24{byte_sel[7]}}, byte_sel} :
                           f3 == 3'b001  ? {{16{half_sel[15]}}, half_sel} :
                           f3 == 3'b100  ? {24'h0, byte_sel} :
                           f3 == 3'b101  ? {16'h0, half_sel} :
                                           bus.mem_rdata;

    // halfword lanes take wdata bytes 0/1 in place; byte stores replicate wdata[7:0]
    always_comb begin
        merged = bus.mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if ((f3 == 3'b000 && a[1:0] == 2'(i)) || (f3 == 3'b001 && a[1] == i[1]))
                merged[8*i +: 8] = f3[0] ? bus.req_wdata[8*(i%2) +: 8] : bus.req_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            if (is_sw || state == WRITE)
                count_q <= count_q + 32'h1;
            if (state == WRITE)
                state <= IDLE;
            else if (is_sub) begin
                state   <= WRITE;
                merge_q <= merged;
            end
        end
    end
endmodule

// File: tb/tb_lsu_subword_rmw.sv
// tb_lsu_subword_rmw: directed checks of loads, RMW stores, faults, reset abort and counter wrap.
module tb_lsu_subword_rmw;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] mem [16];

    lsu_subword_rmw_if bus();

    lsu_subword_rmw dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

    task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = v; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
    endtask

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); set_req(1, 1, 3'b010, a, d);
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0000, 0);
        exp_cnt++;
    endtask

    task automatic test_reset;
        set_req(1, 1, 3'b000, 32'h8000_0000, 32'h1);
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        tests++; if (bus.store_count !== 32'h0) begin fails++; $display("FAIL reset_count got %h want 0", bus.store_count); end
        set_req(1, 1, 3'b010, 32'h8000_0000, 32'h1);
        #1;
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0000, 0); rst_n = 1'b1;
        @(negedge clk); #1;
        tests++; if (bus.store_count !== 32'h0) begin fails++; $display("FAIL idle_count got %h want 0", bus.store_count); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h8000_0011, 32'h8000_0011, 32'h8000_0012, 32'h8000_0012};
        logic [31:0] exp [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899};
        do_sw(32'h8000_0010, 32'h8899_AABB);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_req(1, 0, f3s[i], ads[i], 0); #1;
            tests++; if (bus.load_data !== exp[i]) begin fails++; $display("FAIL load_%0d got %h want %h", i, bus.load_data, exp[i]); end
            tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL load_stall_%0d got %b want 0", i, bus.stall); end
        end
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0010, 0); #1;
        tests++; if (bus.load_data !== 32'h0) begin fails++; $display("FAIL load_idle got %h want 0", bus.load_data); end
    endtask

    task automatic test_sb;
        do_sw(32'h8000_0010, 32'h1122_3344);
        @(negedge clk); set_req(1, 1, 3'b000, 32'h8000_0012, 32'h0000_0055); #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL sb_c0_stall got %b want 1", bus.stall); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL sb_c0_we got %b want 0", bus.mem_we); end
        @(negedge clk); bus.req_wdata = 32'hFFFF_FFFF; #1;
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL sb_c1_we got %b want 1", bus.mem_we); end
        tests++; if (bus.mem_wdata !== 32'h1155_3344) begin fails++; $display("FAIL sb_c1_wdata got %h want 11553344", bus.mem_wdata); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL sb_c1_stall got %b want 0", bus.stall); end
        tests++; if (bus.access_fault !== 1'b0) begin fails++; $display("FAIL sb_c1_fault got %b want 0", bus.access_fault); end
        exp_cnt++;
        @(negedge clk); set_req(1, 0, 3'b010, 32'h8000_0010, 0); #1;
        tests++; if (bus.store_count !== exp_cnt) begin fails++; $display("FAIL sb_count got %h want %h", bus.store_count, exp_cnt); end
        tests++; if (bus.load_data !== 32'h1155_3344) begin fails++; $display("FAIL sb_readback got %h want 11553344", bus.load_data); end
    endtask

    task automatic test_sh_sw;
        do_sw(32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk); set_req(1, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
        @(negedge clk); #1;
        tests++; if (bus.mem_wdata !== 32'hBEEF_FFFF) begin fails++; $display("FAIL sh_wdata got %h want beefffff", bus.mem_wdata); end
        exp_cnt++;
        @(negedge clk); set_req(1, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF); #1;
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL sw_we got %b want 1", bus.mem_we); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL sw_stall got %b want 0", bus.stall); end
        tests++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata got %h want deadbeef", bus.mem_wdata); end
        exp_cnt++;
        @(negedge clk); set_req(1, 0, 3'b010, 32'h8000_0004, 0); #1;
        tests++; if (bus.load_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_readback got %h want deadbeef", bus.load_data); end
        tests++; if (bus.store_count !== exp_cnt) begin fails++; $display("FAIL sw_count got %h want %h", bus.store_count, exp_cnt); end
    endtask

    task automatic test_faults;
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b111, 3'b000, 3'b010};
        logic [31:0] ads [5] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000, 32'h7FFF_FFFC, 32'h8000_1F40};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); set_req(1, wes[i], f3s[i], ads[i], 32'h1234_5678); #1;
            tests++; if (bus.access_fault !== 1'b1) begin fails++; $display("FAIL fault_%0d got %b want 1", i, bus.access_fault); end
            tests++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin fails++; $display("FAIL fault_ctl_%0d got we=%b stall=%b want 0 0", i, bus.mem_we, bus.stall); end
            tests++; if (bus.load_data !== 32'h0) begin fails++; $display("FAIL fault_data_%0d got %h want 0", i, bus.load_data); end
        end
        @(negedge clk); set_req(1, 0, 3'b010, 32'h8000_1F3C, 0); #1;
        tests++; if (bus.access_fault !== 1'b0) begin fails++; $display("FAIL last_word_fault got %b want 0", bus.access_fault); end
        tests++; if (bus.store_count !== exp_cnt) begin fails++; $display("FAIL fault_count got %h want %h", bus.store_count, exp_cnt); end
    endtask

    task automatic test_reset_in_write;
        do_sw(32'h8000_0008, 32'hCAFE_BABE);
        @(negedge clk); set_req(1, 1, 3'b000, 32'h8000_0008, 32'h0000_0077);
        @(negedge clk); #1;
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL rw_write_we got %b want 1", bus.mem_we); end
        rst_n = 1'b0; #1;
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rw_we_drop got %b want 0", bus.mem_we); end
        tests++; if (bus.store_count !== 32'h0) begin fails++; $display("FAIL rw_count got %h want 0", bus.store_count); end
        tests++; if (dut.state !== dut.IDLE) begin fails++; $display("FAIL rw_state got %b want IDLE", dut.state); end
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0008, 0); rst_n = 1'b1;
        @(negedge clk); set_req(1, 0, 3'b010, 32'h8000_0008, 0); #1;
        tests++; if (bus.load_data !== 32'hCAFE_BABE) begin fails++; $display("FAIL rw_unmodified got %h want cafebabe", bus.load_data); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rw_after_stall got %b want 0", bus.stall); end
    endtask

    task automatic test_wrap;
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0000, 0);
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        #1;
        tests++; if (bus.store_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_pre got %h want ffffffff", bus.store_count); end
        set_req(1, 1, 3'b010, 32'h8000_000C, 32'h0BAD_F00D);
        @(negedge clk); set_req(0, 0, 3'b010, 32'h8000_0000, 0); #1;
        tests++; if (bus.store_count !== 32'h0) begin fails++; $display("FAIL wrap_post got %h want 0", bus.store_count); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_sb;
        test_sh_sw;
        test_faults;
        test_reset_in_write;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
